sqrt_remainder_check: RTL and testbench
=======================================

SQRT_REMAINDER_CHECK -- requirements
Module: sqrt_remainder_check

Interface
REQ-001 Parameter NUM_W, default 10, width of the radicand; SHALL be even and at least 4.
REQ-002 Parameter ROOT_W, default NUM_W/2, width of the root; SHALL equal NUM_W/2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 SHALL reset all state immediately, regardless of clk.
REQ-005 in_valid  input  1  SHALL indicate that num and root hold a valid pair from the upstream floor-square-root stage.
REQ-006 in_ready  output  1  SHALL indicate the block can accept a pair this cycle.
REQ-007 num  input  NUM_W  radicand.
REQ-008 root  input  ROOT_W  claimed floor(sqrt(num)).
REQ-009 out_valid  output  1  SHALL indicate that the result outputs are valid.
REQ-010 out_ready  input  1  downstream accept.
REQ-011 rem  output  ROOT_W+1  SHALL carry num - root*root when err=0, and 0 when err=1.
REQ-012 exact  output  1  SHALL be 1 when err=0 and rem=0 (num is a perfect square).
REQ-013 err  output  1  SHALL be 1 when root is not floor(sqrt(num)).

Function
REQ-014 FSM states SHALL be IDLE, MUL, CHECK and DONE; no other reachable state is permitted.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: when in_valid=1, the block SHALL capture num and root, clear the product accumulator, and go to MUL.
REQ-017 MUL: the block SHALL compute root*root by shift-add over exactly ROOT_W cycles, processing one multiplier bit per cycle from LSB to MSB, in an accumulator of NUM_W bits.
REQ-018 After the ROOT_W-th MUL cycle, the FSM SHALL go to CHECK.
REQ-019 CHECK: the block SHALL form diff = num - sq in NUM_W+1 bits, two's complement.
REQ-020 err SHALL be set when diff is negative or diff > 2*root; otherwise rem=diff, with err=0 and exact=(diff==0).
REQ-021 The results SHALL be registered in CHECK, after which the FSM goes to DONE.
REQ-022 DONE: out_valid SHALL be 1 and rem/exact/err SHALL be held stable until out_valid and out_ready are both 1 at a clock edge; the FSM SHALL then return to IDLE.
REQ-023 Latency SHALL be fixed: with acceptance at edge E0, out_valid SHALL rise after edge E0+ROOT_W+1 (6 cycles for the defaults), independent of out_ready.
REQ-024 A new pair SHALL NOT be accepted in the cycle out_valid falls; the earliest next acceptance SHALL be the cycle after the FSM returns to IDLE.
REQ-025 Changes on num or root after acceptance SHALL NOT affect the result in flight.
REQ-026 in_valid asserted outside IDLE SHALL be ignored, with no capture and no error.
REQ-027 out_ready asserted outside DONE SHALL be ignored.
REQ-028 Boundary cases SHALL be handled without overflow: root=0 gives sq=0; root=2^ROOT_W-1 gives sq=(2^ROOT_W-1)^2, which fits NUM_W bits; the maximum rem SHALL be 2*(2^ROOT_W-1) and SHALL fit ROOT_W+1 bits.

Reset
REQ-029 On rst=0 the block SHALL enter IDLE with in_ready=1, out_valid=0, rem=0, exact=0, err=0, and all internal registers cleared.
REQ-030 On reset in any state, including mid-MUL or DONE, the in-flight operation SHALL be discarded and no out_valid pulse SHALL follow.
REQ-031 After rst returns to 1, the first acceptance SHALL be possible on the first rising edge of clk.

Verification
REQ-032 Normal case: num=19, root=4, out_ready=1 -> out_valid 6 cycles after acceptance with rem=3, exact=0, err=0.
REQ-033 Perfect square and overflow edges: num=16, root=4 -> rem=0, exact=1, err=0; num=1023, root=31 -> rem=62, err=0; num=0, root=0 -> rem=0, exact=1.
REQ-034 Wrong root: num=19, root=5 (25>19) -> err=1, rem=0, exact=0; num=24, root=4 (diff 8 > 8 is false) -> rem=8, err=0; num=25, root=4 -> err=1.
REQ-035 Back-pressure: out_ready=0 for 10 cycles in DONE -> out_valid stays 1, outputs stay stable, in_ready stays 0; in_valid pulses in that window are ignored; out_ready=1 -> return to IDLE, and the next pair is accepted one cycle later.
REQ-036 Reset mid-operation: drive rst=0 asynchronously during the 3rd MUL cycle -> outputs clear at once and no out_valid appears; after release, num=19, root=4 -> correct result with nominal latency.
REQ-037 Random back-to-back: 500 random pairs, half with root=floor(sqrt(num)) and half with a random root, plus random out_ready -> every result matches a reference model, and there is no lost or duplicated transfer.

Source files
------------

// File: rtl/sqrt_remainder_check_if.sv
// Purpose : handshake bundle between a floor-square-root stage, the remainder checker and its consumer.
// Latency : n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports   : in_valid/in_ready/num/root (request), out_valid/out_ready/rem/exact/err (result).
interface sqrt_remainder_check_if #(
  parameter int NUM_W  = 10,
  parameter int ROOT_W = NUM_W / 2
);
  logic              in_valid;
  logic              in_ready;
  logic [NUM_W-1:0]  num;
  logic [ROOT_W-1:0] root;
  logic              out_valid;
  logic              out_ready;
  logic [ROOT_W:0]   rem;
  logic              exact;
  logic              err;

  // master: the producer of pairs and consumer of results.
  modport master (
    output in_valid, num, root, out_ready,
    input  in_ready, out_valid, rem, exact, err
  );

  // slave: the checker itself.
  modport slave (
    input  in_valid, num, root, out_ready,
    output in_ready, out_valid, rem, exact, err
  );
endinterface

// File: rtl/sqrt_remainder_check.sv
// Purpose : verifies a claimed root=floor(sqrt(num)) and reports rem=num-root^2, exact and err.
// Latency : fixed; out_valid rises ROOT_W+1 cycles after the acceptance edge.
// Backpressure: one pair in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports   : clk, rst (async active-low), bus (slave modport: request pair in, result out).
module sqrt_remainder_check #(
  parameter int NUM_W  = 10,
  parameter int ROOT_W = NUM_W / 2
) (
  input logic                   clk,
  input logic                   rst,
  sqrt_remainder_check_if.slave bus
);

  if ((NUM_W % 2) != 0 || NUM_W < 4 || ROOT_W != NUM_W / 2) begin : g_param_check
    $error("sqrt_remainder_check: NUM_W must be even and >= 4, ROOT_W must be NUM_W/2");
  end

  localparam int CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROOT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [NUM_W-1:0]  num_q;
  logic [ROOT_W-1:0] root_q;
  logic [NUM_W-1:0]  mcand_q;   // root shifted left once per MUL cycle
  logic [ROOT_W-1:0] mplier_q;  // root shifted right; bit 0 selects the add
  logic [NUM_W-1:0]  acc_q;     // running root*root, never exceeds (2^ROOT_W-1)^2
  logic [CNT_W-1:0]  cnt_q;
  logic [ROOT_W:0]   rem_q;
  logic              exact_q;
  logic              err_q;

  logic              in_ready;
  logic              out_valid;
  logic              mul_last;

  // CHECK-stage arithmetic. The extra top bit of diff is the sign, so a
  // claimed root that is too large shows up as a negative difference.
  logic [NUM_W:0]    diff;
  logic [ROOT_W:0]   twice_root;
  logic              too_big;
  logic              chk_err;

  assign mul_last   = (cnt_q == CNT_LAST);
  assign diff       = {1'b0, num_q} - {1'b0, acc_q};
  assign twice_root = {root_q, 1'b0};
  assign too_big    = diff[NUM_W-1:0] > {{(NUM_W-ROOT_W-1){1'b0}}, twice_root};
  assign chk_err    = diff[NUM_W] | too_big;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = MUL;
      end
      MUL: begin
        if (mul_last) state_d = CHECK;
      end
      CHECK: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_q    <= '0;
      root_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      exact_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            num_q    <= bus.num;
            root_q   <= bus.root;
            mcand_q  <= {{(NUM_W-ROOT_W){1'b0}}, bus.root};
            mplier_q <= bus.root;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        CHECK: begin
          // With no error, 0 <= diff <= 2*root, so it fits ROOT_W+1 bits.
          err_q   <= chk_err;
          rem_q   <= chk_err ? '0 : diff[ROOT_W:0];
          exact_q <= ~chk_err & (diff == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.rem       = rem_q;
  assign bus.exact     = exact_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_sqrt_remainder_check.sv
// Purpose : self-checking bench for sqrt_remainder_check (directed edges, back-pressure, reset, random).
// Latency : expects out_valid ROOT_W+1 cycles after acceptance.
// Backpressure: drives random out_ready; a scoreboard queue tracks results in flight.
module tb_sqrt_remainder_check;
  localparam int NUM_W  = 10;
  localparam int ROOT_W = 5;
  localparam int LAT    = ROOT_W + 1;

  typedef struct {
    int n;
    int r;
    int rem;
    bit exact;
    bit err;
  } res_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sqrt_remainder_check_if #(.NUM_W(NUM_W), .ROOT_W(ROOT_W)) bus ();

  sqrt_remainder_check #(.NUM_W(NUM_W), .ROOT_W(ROOT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the true floor square root by search, then the remainder.
  function automatic int isqrt(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  function automatic res_t model(input int n, input int r);
    res_t x;
    x.n     = n;
    x.r     = r;
    x.err   = (r != isqrt(n));
    x.rem   = x.err ? 0 : n - r * r;
    x.exact = !x.err && (x.rem == 0);
    return x;
  endfunction

  // Presents one pair in IDLE, measures cycles to out_valid, then pops the result.
  task automatic do_txn(input int n, input int r, output logic [ROOT_W:0] o_rem,
                        output logic o_exact, output logic o_err, output int lat);
    bus.num       = NUM_W'(n);
    bus.root      = ROOT_W'(r);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.num      = NUM_W'($urandom);
    bus.root     = ROOT_W'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    o_rem   = bus.rem;
    o_exact = bus.exact;
    o_err   = bus.err;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.rem !== '0) begin
      errors++; $display("FAIL reset_rem got %0d want 0", bus.rem);
    end
    checks++;
    if (bus.exact !== 1'b0) begin
      errors++; $display("FAIL reset_exact got %b want 0", bus.exact);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b want 0", bus.err);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_directed();
    int tn[7]   = '{19, 16, 1023, 0, 19, 24, 25};
    int tr[7]   = '{4, 4, 31, 0, 5, 4, 4};
    int trem[7] = '{3, 0, 62, 0, 0, 8, 0};
    bit tex[7]  = '{0, 1, 0, 1, 0, 0, 0};
    bit terr[7] = '{0, 0, 0, 0, 1, 0, 1};
    logic [ROOT_W:0] g_rem;
    logic g_ex, g_er;
    int lat;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL dir_ready_%0d got %b want 1", i, bus.in_ready);
      end
      do_txn(tn[i], tr[i], g_rem, g_ex, g_er, lat);
      checks++;
      if (lat !== LAT) begin
        errors++; $display("FAIL dir_latency num=%0d root=%0d got %0d want %0d", tn[i], tr[i], lat, LAT);
      end
      checks++;
      if ({g_rem, g_ex, g_er} !== {6'(trem[i]), tex[i], terr[i]}) begin
        errors++;
        $display("FAIL dir_result num=%0d root=%0d got rem=%0d exact=%b err=%b want rem=%0d exact=%b err=%b",
                 tn[i], tr[i], g_rem, g_ex, g_er, trem[i], tex[i], terr[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t e;
    int lat;
    logic [ROOT_W:0] g_rem;
    logic g_ex, g_er;
    e = model(19, 4);
    bus.num       = 10'd19;
    bus.root      = 5'd4;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    // in_valid stays high with different data while the pair is in flight
    bus.num  = 10'd25;
    bus.root = 5'd7;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      bus.num  = NUM_W'($urandom);
      bus.root = ROOT_W'($urandom);
    end
    checks++;
    if (lat !== LAT) begin
      errors++; $display("FAIL bp_latency got %0d want %0d", lat, LAT);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'($urandom);
      bus.num      = NUM_W'($urandom);
      bus.root     = ROOT_W'($urandom);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.rem, bus.exact, bus.err} !==
          {1'b1, 1'b0, 6'(e.rem), e.exact, e.err}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got vld=%b rdy=%b rem=%0d ex=%b err=%b want vld=1 rdy=0 rem=%0d ex=%b err=%b",
                 i, bus.out_valid, bus.in_ready, bus.rem, bus.exact, bus.err, e.rem, e.exact, e.err);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    e = model(16, 4);
    do_txn(16, 4, g_rem, g_ex, g_er, lat);
    checks++;
    if ({g_rem, g_ex, g_er, lat} !== {6'(e.rem), e.exact, e.err, LAT}) begin
      errors++;
      $display("FAIL bp_next got rem=%0d ex=%b err=%b lat=%0d want rem=%0d ex=%b err=%b lat=%0d",
               g_rem, g_ex, g_er, lat, e.rem, e.exact, e.err, LAT);
    end
  endtask

  task automatic test_reset_mid();
    res_t e;
    int lat;
    logic [ROOT_W:0] g_rem;
    logic g_ex, g_er;
    bit seen;
    bus.num       = 10'd19;
    bus.root      = 5'd4;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.rem, bus.exact, bus.err} !== {1'b1 ^ 1'b1, 1'b1, 6'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_clear got vld=%b rdy=%b rem=%0d ex=%b err=%b want vld=0 rdy=1 rem=0 ex=0 err=0",
               bus.out_valid, bus.in_ready, bus.rem, bus.exact, bus.err);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL midrst_no_valid got out_valid pulse want none");
    end
    rst = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_ready got %b want 1", bus.in_ready);
    end
    e = model(19, 4);
    do_txn(19, 4, g_rem, g_ex, g_er, lat);
    checks++;
    if ({g_rem, g_ex, g_er, lat} !== {6'(e.rem), e.exact, e.err, LAT}) begin
      errors++;
      $display("FAIL midrst_after got rem=%0d ex=%b err=%b lat=%0d want rem=%0d ex=%b err=%b lat=%0d",
               g_rem, g_ex, g_er, lat, e.rem, e.exact, e.err, LAT);
    end
  endtask

  task automatic test_random();
    res_t q[$];
    int   got;
    int   cyc;
    got = 0;
    cyc = 0;
    fork
      begin
        for (int i = 0; i < 500; i++) begin
          int n;
          int r;
          int w;
          n = int'($urandom_range(0, 1023));
          r = (i % 2 == 0) ? isqrt(n) : int'($urandom_range(0, 31));
          w = 0;
          // junk requests while busy must be ignored
          bus.in_valid = 1'($urandom);
          bus.num      = NUM_W'($urandom);
          bus.root     = ROOT_W'($urandom);
          while (!bus.in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
            bus.in_valid = 1'($urandom);
            bus.num      = NUM_W'($urandom);
            bus.root     = ROOT_W'($urandom);
          end
          bus.in_valid = 1'b1;
          bus.num      = NUM_W'(n);
          bus.root     = ROOT_W'(r);
          @(posedge clk); #1;
          q.push_back(model(n, r));
          bus.in_valid = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
      begin
        while (got < 500 && cyc < 20000) begin
          @(posedge clk); #1;
          cyc++;
          bus.out_ready = 1'($urandom);
          if (bus.out_valid && bus.out_ready) begin
            got++;
            checks++;
            if (q.size() == 0) begin
              errors++; $display("FAIL rand_extra transfer %0d got unexpected result want none", got);
            end else begin
              res_t e;
              e = q.pop_front();
              if ({bus.rem, bus.exact, bus.err} !== {6'(e.rem), e.exact, e.err}) begin
                errors++;
                $display("FAIL rand_result num=%0d root=%0d got rem=%0d ex=%b err=%b want rem=%0d ex=%b err=%b",
                         e.n, e.r, bus.rem, bus.exact, bus.err, e.rem, e.exact, e.err);
              end
            end
          end
        end
      end
    join
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (got != 500 || q.size() != 0) begin
      errors++; $display("FAIL rand_count got %0d transfers %0d pending want 500 transfers 0 pending", got, q.size());
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.num       = '0;
    bus.root      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
